// File: rtl/ans_table_sender_pkg.sv
// ---------------------------------------------------------------------------
// ans_table_sender_pkg
// Shared ANS definitions: default table geometry and the sender's handshake
// state encoding. The loader side imports the same package so both ends of
// the frequency-table link agree on sizes and state names.
// ---------------------------------------------------------------------------
package ans_table_sender_pkg;

  // Width of one symbol count.
  localparam int ANS_CNT_WIDTH = 8;
  // Number of symbols in the frequency table.
  localparam int ANS_SYM_COUNT = 16;
  // Symbol index width; 2**ANS_SYM_WIDTH must cover ANS_SYM_COUNT.
  localparam int ANS_SYM_WIDTH = 4;

  // Sender handshake states.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_REQ  = 3'd2,
    ST_REL  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

endpackage : ans_table_sender_pkg

// File: rtl/ans_table_sender.sv
// ---------------------------------------------------------------------------
// ans_table_sender
// Transmits a snapshot of a symbol frequency table, one count per 4-phase
// handshake, to the loader-side receiver.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset (wins over start)
//   counts    in   frequency table; snapshotted when start is taken in IDLE
//   start     in   begin a transfer; ignored (not queued) while busy
//   out_data  out  count currently offered (held through the release phase)
//   out_vld   out  4-phase request
//   out_rdy   in   4-phase acknowledge: high = ready, low = captured
//   busy      out  high whenever the sender is not idle
//   sym_idx   out  index of the symbol in flight; holds final value after done
//   total     out  running sum of acknowledged counts; holds after done
//   done      out  one-cycle pulse after the last acknowledge completes
// ---------------------------------------------------------------------------
module ans_table_sender
  import ans_table_sender_pkg::*;
#(
  parameter int CNT_WIDTH = ANS_CNT_WIDTH,
  parameter int SYM_COUNT = ANS_SYM_COUNT,
  parameter int SYM_WIDTH = ANS_SYM_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [SYM_COUNT-1:0][CNT_WIDTH-1:0] counts,
  input  logic                                start,
  output logic [CNT_WIDTH-1:0]                out_data,
  output logic                                out_vld,
  input  logic                                out_rdy,
  output logic                                busy,
  output logic [SYM_WIDTH-1:0]                sym_idx,
  output logic [CNT_WIDTH+SYM_WIDTH-1:0]      total,
  output logic                                done
);

  // The extra SYM_WIDTH bits cover SYM_COUNT full-scale counts without wrap.
  localparam int TOT_WIDTH = CNT_WIDTH + SYM_WIDTH;
  localparam logic [SYM_WIDTH-1:0] LAST_IDX = SYM_WIDTH'(SYM_COUNT - 1);

  state_e                              state_q, state_d;
  logic [SYM_COUNT-1:0][CNT_WIDTH-1:0] snap_q;
  logic [SYM_WIDTH-1:0]                idx_q, idx_d;
  logic [TOT_WIDTH-1:0]                total_q, total_d;
  logic [CNT_WIDTH-1:0]                data_q, data_d;
  logic                                vld_q, busy_q, done_q;

  // Next state, index, total and offered data.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis would infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    total_d = total_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ARM;
          idx_d   = '0;
          total_d = '0;
        end
      end
      // Wait for the receiver to be ready before raising a request, so a
      // receiver still recovering from a previous transfer is never rushed.
      ST_ARM: begin
        if (out_rdy) state_d = ST_REQ;
      end
      // Acknowledge (out_rdy low) means the count was captured: account it.
      ST_REQ: begin
        if (!out_rdy) begin
          state_d = ST_REL;
          total_d = total_q + TOT_WIDTH'(snap_q[idx_q]);
        end
      end
      // Request dropped; wait for the receiver to release before moving on.
      ST_REL: begin
        if (out_rdy) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_REQ;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Load the offered count on REQ entry; it then stays stable through REL.
    data_d = (state_d == ST_REQ) ? snap_q[idx_d] : data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the snapshot register file is reset along with the control
      // state, so a cleared block never offers stale table contents.
      state_q <= ST_IDLE;
      snap_q  <= '0;
      idx_q   <= '0;
      total_q <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // of the previous cycle, independent of statement order.
      state_q <= state_d;
      idx_q   <= idx_d;
      total_q <= total_d;
      data_q  <= data_d;
      if (state_q == ST_IDLE && start) snap_q <= counts;
      // Outputs are decoded from the next state so they are glitch-free
      // flops that line up exactly with the state register.
      vld_q   <= (state_d == ST_REQ);
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign out_data = data_q;
  assign out_vld  = vld_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign sym_idx  = idx_q;
  assign total    = total_q;

endmodule : ans_table_sender

// File: tb/tb_ans_table_sender.sv
// ---------------------------------------------------------------------------
// tb_ans_table_sender
// Self-checking bench: a 4-phase receiver that acknowledges and releases in
// one cycle each (with an optional hold-off), a protocol monitor, and a
// reference model that simply expects the start-time table, its arithmetic
// sum and a single done pulse.
// ---------------------------------------------------------------------------
module tb_ans_table_sender;

  localparam int CW = 8;
  localparam int SC = 16;
  localparam int SW = 4;
  localparam int TW = CW + SW;

  typedef logic [SC-1:0][CW-1:0] table_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  table_t        counts;
  logic [CW-1:0] out_data;
  logic          out_vld;
  logic          out_rdy;
  logic          busy;
  logic [SW-1:0] sym_idx;
  logic [TW-1:0] total;
  logic          done;

  ans_table_sender #(
    .CNT_WIDTH(CW),
    .SYM_COUNT(SC),
    .SYM_WIDTH(SW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .counts  (counts),
    .start   (start),
    .out_data(out_data),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .busy    (busy),
    .sym_idx (sym_idx),
    .total   (total),
    .done    (done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Receiver / monitor state.
  int            cyc = 0;
  int            hold_cnt = 0;
  logic          rx_next = 1'b1;
  logic [CW-1:0] rx_q[$];
  int            done_cnt = 0;
  int            first_req_cyc = -1;
  int            done_cyc = -1;
  int            proto_err = 0;
  int            vld_in_hold = 0;
  logic          prev_vld = 1'b0;
  logic          prev_rdy = 1'b1;

  always @(posedge clk) cyc++;

  // Receiver: captures on the first request cycle, answers one cycle later.
  always @(negedge clk) begin
    if (out_vld && out_rdy) begin
      rx_q.push_back(out_data);
      if (first_req_cyc < 0) first_req_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (!rst) begin
      if (out_vld && !prev_vld && !prev_rdy) proto_err++;
      if (!out_vld && prev_vld && prev_rdy) proto_err++;
    end
    if (hold_cnt > 0) begin
      if (out_vld) vld_in_hold++;
      hold_cnt--;
      rx_next = 1'b0;
    end else begin
      rx_next = ~out_vld;
    end
    prev_vld = out_vld;
    prev_rdy = out_rdy;
  end

  always @(posedge clk) begin
    #1 out_rdy = rx_next;
  end

  // Reference model helpers.
  function automatic int table_errs(input table_t c);
    int e = 0;
    if (rx_q.size() != SC) return SC + 1;
    for (int i = 0; i < SC; i++) if (rx_q[i] !== c[i]) e++;
    return e;
  endfunction

  function automatic int sum_of(input table_t c);
    int s = 0;
    for (int i = 0; i < SC; i++) s += int'(c[i]);
    return s;
  endfunction

  // Stimulus helpers (no checking here).
  task automatic start_xfer(input table_t c, input int hold);
    @(posedge clk); #1;
    counts        = c;
    rx_q.delete();
    done_cnt      = 0;
    done_cyc      = -1;
    first_req_cyc = -1;
    proto_err     = 0;
    vld_in_hold   = 0;
    hold_cnt      = hold;
    start         = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) begin
        timed_out = 1'b0;
        break;
      end
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; counts = '0; out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({out_vld, busy, done, sym_idx, total, out_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got vld=%0b busy=%0b done=%0b idx=%0d total=%0d data=%0d expected all 0",
               out_vld, busy, done, sym_idx, total, out_data);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_loopback();
    table_t c;
    bit     to;
    for (int i = 0; i < SC; i++) c[i] = CW'(i + 1);
    start_xfer(c, 0);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL loop_busy: got %0b expected 1", busy);
    end
    wait_done(to);
    n_tests++;
    if (to) begin n_fail++; $display("FAIL loop_timeout: got no done expected done"); end
    n_tests++;
    if (table_errs(c) != 0) begin
      n_fail++; $display("FAIL loop_table: got %0d bad entries (size %0d) expected 0", table_errs(c), rx_q.size());
    end
    n_tests++;
    if (total !== TW'(136)) begin n_fail++; $display("FAIL loop_total: got %0d expected 136", total); end
    n_tests++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL loop_done_cnt: got %0d expected 1", done_cnt); end
    n_tests++;
    if (done_cyc - first_req_cyc != 64) begin
      n_fail++; $display("FAIL loop_cycles: got %0d expected 64", done_cyc - first_req_cyc);
    end
    n_tests++;
    if (sym_idx !== SW'(SC - 1) || busy !== 1'b0) begin
      n_fail++; $display("FAIL loop_final: got idx=%0d busy=%0b expected idx=15 busy=0", sym_idx, busy);
    end
    n_tests++;
    if (proto_err != 0) begin n_fail++; $display("FAIL loop_protocol: got %0d violations expected 0", proto_err); end
  endtask

  task automatic test_arm_hold();
    table_t c;
    bit     to;
    for (int i = 0; i < SC; i++) c[i] = CW'($urandom_range(0, 255));
    start_xfer(c, 12);
    wait_done(to);
    n_tests++;
    if (vld_in_hold != 0) begin n_fail++; $display("FAIL hold_vld: got %0d vld cycles expected 0", vld_in_hold); end
    n_tests++;
    if (to || table_errs(c) != 0) begin
      n_fail++; $display("FAIL hold_table: got %0d bad entries timeout=%0b expected 0", table_errs(c), to);
    end
    n_tests++;
    if (total !== TW'(sum_of(c)) || proto_err != 0) begin
      n_fail++; $display("FAIL hold_total: got %0d (proto %0d) expected %0d", total, proto_err, sum_of(c));
    end
  endtask

  task automatic test_snapshot();
    table_t c;
    bit     to;
    for (int i = 0; i < SC; i++) c[i] = CW'($urandom_range(0, 200));
    start_xfer(c, 0);
    counts = '1;
    wait_done(to);
    n_tests++;
    if (to || table_errs(c) != 0) begin
      n_fail++; $display("FAIL snapshot_table: got %0d bad entries timeout=%0b expected 0", table_errs(c), to);
    end
    n_tests++;
    if (total !== TW'(sum_of(c))) begin
      n_fail++; $display("FAIL snapshot_total: got %0d expected %0d", total, sum_of(c));
    end
  endtask

  task automatic test_restart_ignored();
    table_t c;
    bit     to, found;
    for (int i = 0; i < SC; i++) c[i] = CW'($urandom_range(1, 255));
    start_xfer(c, 0);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_vld && sym_idx == SW'(5)) begin found = 1'b1; break; end
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(to);
    repeat (20) @(posedge clk);
    #1;
    n_tests++;
    if (!found || to) begin n_fail++; $display("FAIL restart_reach: got found=%0b timeout=%0b expected 1/0", found, to); end
    n_tests++;
    if (rx_q.size() != SC || done_cnt != 1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL restart_ignored: got %0d transfers %0d dones busy=%0b expected 16 1 0",
                         rx_q.size(), done_cnt, busy);
    end
    n_tests++;
    if (table_errs(c) != 0) begin n_fail++; $display("FAIL restart_table: got %0d bad entries expected 0", table_errs(c)); end
  endtask

  task automatic test_reset_mid();
    table_t c;
    bit     to, found;
    for (int i = 0; i < SC; i++) c[i] = CW'($urandom_range(1, 255));
    start_xfer(c, 0);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_vld && sym_idx == SW'(7)) begin found = 1'b1; break; end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (!found || out_vld !== 1'b0 || busy !== 1'b0 || total !== '0) begin
      n_fail++; $display("FAIL midreset_outputs: got found=%0b vld=%0b busy=%0b total=%0d expected 1 0 0 0",
                         found, out_vld, busy, total);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    n_tests++;
    if (done_cnt != 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL midreset_done: got %0d dones busy=%0b expected 0 0", done_cnt, busy);
    end
    for (int i = 0; i < SC; i++) c[i] = CW'($urandom_range(0, 255));
    start_xfer(c, 0);
    wait_done(to);
    n_tests++;
    if (to || table_errs(c) != 0 || total !== TW'(sum_of(c)) || done_cnt != 1) begin
      n_fail++; $display("FAIL midreset_restart: got %0d bad entries total=%0d dones=%0d expected 0 %0d 1",
                         table_errs(c), total, done_cnt, sum_of(c));
    end
  endtask

  task automatic test_extremes();
    table_t c;
    bit     to;
    c = '1;
    start_xfer(c, 0);
    wait_done(to);
    n_tests++;
    if (to || total !== TW'(4080)) begin
      n_fail++; $display("FAIL max_total: got %0d timeout=%0b expected 4080", total, to);
    end
    c[3] = '0;
    start_xfer(c, 0);
    wait_done(to);
    n_tests++;
    if (to || rx_q.size() != SC || table_errs(c) != 0 || rx_q[3] !== '0) begin
      n_fail++; $display("FAIL zero_count: got size=%0d bad=%0d expected 16 entries with entry3=0",
                         rx_q.size(), table_errs(c));
    end
    n_tests++;
    if (total !== TW'(3825)) begin n_fail++; $display("FAIL zero_total: got %0d expected 3825", total); end
  endtask

  task automatic test_random();
    table_t c;
    bit     to;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < SC; i++) c[i] = CW'($urandom_range(0, 255));
      start_xfer(c, int'($urandom_range(0, 5)));
      wait_done(to);
      n_tests++;
      if (to || table_errs(c) != 0 || total !== TW'(sum_of(c)) || done_cnt != 1 || proto_err != 0) begin
        n_fail++; $display("FAIL random_%0d: got bad=%0d total=%0d dones=%0d proto=%0d expected 0 %0d 1 0",
                           r, table_errs(c), total, done_cnt, proto_err, sum_of(c));
      end
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_arm_hold();
    test_snapshot();
    test_restart_ignored();
    test_reset_mid();
    test_extremes();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_ans_table_sender
